// File: rtl/dff_monitor.sv
// -----------------------------------------------------------------------------
// dff_monitor
//
// Run-time checker for a single D flip-flop with synchronous active-high reset,
// synchronous active-high set and complementary outputs. It observes the
// flop's inputs and outputs on the same clock. A golden model
// (reset > set > D) predicts Q. Mismatches on Q or Q_n are counted,
// timestamped and flagged.
//
// Parameters
//   CNT_W        width of err_count (saturating)
//   CYC_W        width of cycle_count / first_err_cycle (saturating)
//   STOP_ON_ERR  1 = freeze in FAIL on first mismatch, 0 = keep checking
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-low; clears all state
//   en               1 = monitor active, 0 = return to IDLE
//   obs_reset        observed flop reset (active-high)
//   obs_set          observed flop set (active-high)
//   obs_D            observed flop data input
//   obs_Q            observed flop Q
//   obs_Q_n          observed flop Q_n
//   checking         1 while in CHECK
//   err_flag         sticky: at least one mismatch since last arm
//   err_count        mismatches since last arm, saturating
//   first_err_cycle  cycle_count value at first mismatch (valid if err_flag)
//   cycle_count      compared cycles since last arm, saturating
// -----------------------------------------------------------------------------
module dff_monitor #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CYC_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             obs_reset,
    input  logic             obs_set,
    input  logic             obs_D,
    input  logic             obs_Q,
    input  logic             obs_Q_n,
    output logic             checking,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CYC_W-1:0] first_err_cycle,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

    state_e           state_q, state_d;
    logic             ref_q, ref_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CYC_W-1:0] first_err_q, first_err_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;

    logic ref_next;
    logic mismatch;

    // Golden flop: reset wins over set, set wins over D.
    assign ref_next = obs_reset ? 1'b0 : (obs_set ? 1'b1 : obs_D);

    // ref_q holds what the flop should be showing during this cycle.
    assign mismatch = (obs_Q != ref_q) | (obs_Q_n != ~ref_q);

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case below leaves a variable unassigned (no latch).
        state_d     = state_q;
        ref_d       = ref_q;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        cycle_d     = cycle_q;

        unique case (state_q)
            IDLE: begin
                // Arming clears the results; otherwise they stay visible.
                if (en) begin
                    state_d     = SYNC;
                    err_flag_d  = 1'b0;
                    err_count_d = '0;
                    first_err_d = '0;
                    cycle_d     = '0;
                end
            end

            SYNC: begin
                // First model load; nothing to compare against yet.
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    ref_d   = ref_next;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    ref_d = ref_next;
                    if (cycle_q != '1) begin
                        cycle_d = cycle_q + CycOne;
                    end
                    if (mismatch) begin
                        err_flag_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CntOne;
                        end
                        // Timestamp uses the count before this edge's increment.
                        if (!err_flag_q) begin
                            first_err_d = cycle_q;
                        end
                        if (STOP_ON_ERR) begin
                            state_d = FAIL;
                        end
                    end
                end
            end

            FAIL: begin
                // Everything frozen until en drops or reset.
                if (!en) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register here; there
        // is no memory array, so nothing is deliberately left unreset.
        if (!reset) begin
            state_q     <= IDLE;
            ref_q       <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            cycle_q     <= cycle_d;
        end
    end

    // Outputs come straight from registers; no obs_* input reaches them
    // combinationally.
    assign checking        = (state_q == CHECK);
    assign err_flag        = err_flag_q;
    assign err_count       = err_count_q;
    assign first_err_cycle = first_err_q;
    assign cycle_count     = cycle_q;

endmodule
